// File: rtl/riscv_ctrl_pkg.sv
// Purpose: shared RV32 control encodings and the decoded control bundle type.
// Contents: opcode constants, ALU op codes, immediate-format and result-source
//           encodings, ctrl_bundle_t, and the func3-to-ALU helper.
package riscv_ctrl_pkg;

  localparam int unsigned ALU_CODE_W = 4;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT   = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU  = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL   = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL   = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA   = 4'd9;
  localparam logic [ALU_CODE_W-1:0] ALU_PASSB = 4'd10;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL   = 4'd11;
  localparam logic [ALU_CODE_W-1:0] ALU_MULH  = 4'd12;
  localparam logic [ALU_CODE_W-1:0] ALU_DIV   = 4'd13;
  localparam logic [ALU_CODE_W-1:0] ALU_REM   = 4'd14;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic [1:0]            result_src;
    logic                  alu_src;
    logic                  alu_src_a_pc;
    logic [2:0]            imm_src;
    logic [ALU_CODE_W-1:0] alu_ctrl;
    logic                  branch;
    logic [2:0]            branch_type;
    logic                  jump;
    logic                  jalr;
    logic                  illegal;
  } ctrl_bundle_t;

  // alt selects sub (func3 000) or sra (func3 101); ignored otherwise
  function automatic logic [ALU_CODE_W-1:0] alu_from_f3(input logic [2:0] f3,
                                                       input logic alt);
    logic [ALU_CODE_W-1:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_ctrl_decode_comb.sv
// Purpose: pure combinational RV32I(+M) instruction-to-control decode.
// Ports: i_opcode/i_funct3/i_funct7 - instruction fields
//        o_ctrl   - decoded control bundle (zeroed except illegal on bad encodings)
//        o_is_mdu - instruction is a multi-cycle M-extension op
module ctrl_decode_comb
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [6:0]   i_opcode,
  input  logic [2:0]   i_funct3,
  input  logic [6:0]   i_funct7,
  output ctrl_bundle_t o_ctrl,
  output logic         o_is_mdu
);

  logic w_legal;

  always_comb begin
    o_ctrl   = '0;
    o_is_mdu = 1'b0;
    w_legal  = 1'b1;
    case (i_opcode)
      OP_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.result_src = RES_MEM;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.imm_src    = IMM_I;
        o_ctrl.alu_ctrl   = ALU_ADD;
        w_legal = i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OP_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_S;
        o_ctrl.alu_ctrl  = ALU_ADD;
        w_legal = i_funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OP_R: begin
        o_ctrl.reg_write = 1'b1;
        if (i_funct7 == 7'b0000000) begin
          o_ctrl.alu_ctrl = alu_from_f3(i_funct3, 1'b0);
        end else if (i_funct7 == 7'b0100000 &&
                     (i_funct3 == 3'b000 || i_funct3 == 3'b101)) begin
          o_ctrl.alu_ctrl = alu_from_f3(i_funct3, 1'b1);
        end else if (EN_MEXT && i_funct7 == 7'b0000001 &&
                     i_funct3 inside {3'b000, 3'b001, 3'b100, 3'b110}) begin
          o_is_mdu = 1'b1;
          case (i_funct3)
            3'b000:  o_ctrl.alu_ctrl = ALU_MUL;
            3'b001:  o_ctrl.alu_ctrl = ALU_MULH;
            3'b100:  o_ctrl.alu_ctrl = ALU_DIV;
            default: o_ctrl.alu_ctrl = ALU_REM;
          endcase
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_I: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_I;
        // addi never subtracts; only shifts carry func7 in the immediate
        o_ctrl.alu_ctrl  = alu_from_f3(i_funct3, (i_funct3 == 3'b101) && i_funct7[5]);
        if (i_funct3 == 3'b001)
          w_legal = (i_funct7 == 7'b0000000);
        else if (i_funct3 == 3'b101)
          w_legal = (i_funct7 == 7'b0000000) || (i_funct7 == 7'b0100000);
      end
      OP_BR: begin
        o_ctrl.branch      = 1'b1;
        o_ctrl.imm_src     = IMM_B;
        o_ctrl.alu_ctrl    = ALU_SUB;
        o_ctrl.branch_type = i_funct3;
        w_legal = !(i_funct3 inside {3'b010, 3'b011});
      end
      OP_LUI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_U;
        o_ctrl.alu_ctrl  = ALU_PASSB;
      end
      OP_AUIPC: begin
        o_ctrl.reg_write    = 1'b1;
        o_ctrl.alu_src      = 1'b1;
        o_ctrl.alu_src_a_pc = 1'b1;
        o_ctrl.imm_src      = IMM_U;
        o_ctrl.alu_ctrl     = ALU_ADD;
      end
      OP_JAL: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.imm_src    = IMM_J;
        o_ctrl.jump       = 1'b1;
        o_ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.imm_src    = IMM_I;
        o_ctrl.jump       = 1'b1;
        o_ctrl.jalr       = 1'b1;
        o_ctrl.result_src = RES_PC4;
        w_legal = (i_funct3 == 3'b000);
      end
      default: w_legal = 1'b0;
    endcase
    // illegal encodings become a flagged bubble with no side effects
    if (!w_legal) begin
      o_ctrl         = '0;
      o_ctrl.illegal = 1'b1;
      o_is_mdu       = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Purpose: RV32 control decoder plus ID/EX control register with valid/ready
//          handshake, flush, multi-cycle MUL/DIV occupancy and illegal counter.
// Ports: clk/reset (sync, active-high); InstrD/in_valid/in_ready - D-side input;
//        flush_e kills E; out_ready/out_valid - E-side handshake;
//        *E - registered control bundle; ill_count - saturating illegal count.
module decode_ctrl_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W  = 4,
  parameter bit          EN_MEXT    = 1'b1,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned ILL_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          InstrD,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush_e,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic [1:0]           ResultSrcE,
  output logic                 ALUSrcE,
  output logic                 ALUSrcAPCE,
  output logic [2:0]           ImmSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 BranchE,
  output logic [2:0]           BranchTypeE,
  output logic                 JumpE,
  output logic                 JalrE,
  output logic                 IllegalE,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam int unsigned CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MULDIV_LAT - 1);

  ctrl_bundle_t          w_ctrl;
  logic                  w_is_mdu;
  logic                  w_xfer;
  logic                  w_retire;
  logic                  w_unused;
  ctrl_bundle_t          r_ctrl;
  logic                  r_out_valid;
  logic [CNT_W-1:0]      r_mdu_cnt;
  logic [ILL_CNT_W-1:0]  r_ill_cnt;

  // register/immediate fields are consumed by the datapath, not here
  assign w_unused = ^InstrD[24:7];

  ctrl_decode_comb #(.EN_MEXT(EN_MEXT)) u_dec (
    .i_opcode (InstrD[6:0]),
    .i_funct3 (InstrD[14:12]),
    .i_funct7 (InstrD[31:25]),
    .o_ctrl   (w_ctrl),
    .o_is_mdu (w_is_mdu)
  );

  // E slot is free when empty, or when its op retires this cycle
  assign in_ready = !flush_e && (!r_out_valid || (out_ready && r_mdu_cnt == '0));
  assign w_xfer   = in_valid && in_ready;
  assign w_retire = r_out_valid && out_ready && (r_mdu_cnt == '0);

  // E register, MUL/DIV occupancy counter and illegal counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl      <= '0;
      r_out_valid <= 1'b0;
      r_mdu_cnt   <= '0;
      r_ill_cnt   <= '0;
    end else if (flush_e) begin
      r_ctrl      <= '0;
      r_out_valid <= 1'b0;
      r_mdu_cnt   <= '0;
    end else if (w_xfer) begin
      r_ctrl      <= w_ctrl;
      r_out_valid <= 1'b1;
      r_mdu_cnt   <= w_is_mdu ? MDU_LOAD : '0;
      if (w_ctrl.illegal && r_ill_cnt != '1)
        r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
    end else begin
      if (r_mdu_cnt != '0)
        r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
      // a retired slot becomes a bubble
      if (w_retire) begin
        r_ctrl      <= '0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign RegWriteE   = r_ctrl.reg_write;
  assign MemWriteE   = r_ctrl.mem_write;
  assign ResultSrcE  = r_ctrl.result_src;
  assign ALUSrcE     = r_ctrl.alu_src;
  assign ALUSrcAPCE  = r_ctrl.alu_src_a_pc;
  assign ImmSrcE     = r_ctrl.imm_src;
  assign ALUControlE = ALUCTRL_W'(r_ctrl.alu_ctrl);
  assign BranchE     = r_ctrl.branch;
  assign BranchTypeE = r_ctrl.branch_type;
  assign JumpE       = r_ctrl.jump;
  assign JalrE       = r_ctrl.jalr;
  assign IllegalE    = r_ctrl.illegal;
  assign ill_count   = r_ill_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Purpose: self-checking bench for decode_ctrl_pipe: table of decode vectors
//          plus hand sequences for handshake, M-op occupancy, flush, stall,
//          illegal-counter saturation and reset mid-operation.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic        in_valid, flush_e, out_ready;

  logic       in_ready, out_valid, RegWriteE, MemWriteE, ALUSrcE, ALUSrcAPCE;
  logic [1:0] ResultSrcE;
  logic [2:0] ImmSrcE, BranchTypeE;
  logic [3:0] ALUControlE;
  logic       BranchE, JumpE, JalrE, IllegalE;
  logic [7:0] ill_count;

  logic       nm_in_ready, nm_out_valid, nm_RegWriteE, nm_MemWriteE, nm_ALUSrcE, nm_ALUSrcAPCE;
  logic [1:0] nm_ResultSrcE;
  logic [2:0] nm_ImmSrcE, nm_BranchTypeE;
  logic [3:0] nm_ALUControlE;
  logic       nm_BranchE, nm_JumpE, nm_JalrE, nm_IllegalE;
  logic [7:0] nm_ill_count;

  int n_checks;
  int n_errors;
  int exp_ill;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.ALUCTRL_W(4), .EN_MEXT(1'b1), .MULDIV_LAT(4), .ILL_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .in_valid(in_valid), .in_ready(in_ready),
    .flush_e(flush_e), .out_ready(out_ready), .out_valid(out_valid),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .ALUSrcAPCE(ALUSrcAPCE), .ImmSrcE(ImmSrcE),
    .ALUControlE(ALUControlE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .JumpE(JumpE), .JalrE(JalrE), .IllegalE(IllegalE), .ill_count(ill_count)
  );

  decode_ctrl_pipe #(.ALUCTRL_W(4), .EN_MEXT(1'b0), .MULDIV_LAT(4), .ILL_CNT_W(8)) dut_nm (
    .clk(clk), .reset(reset), .InstrD(InstrD), .in_valid(in_valid), .in_ready(nm_in_ready),
    .flush_e(flush_e), .out_ready(out_ready), .out_valid(nm_out_valid),
    .RegWriteE(nm_RegWriteE), .MemWriteE(nm_MemWriteE), .ResultSrcE(nm_ResultSrcE),
    .ALUSrcE(nm_ALUSrcE), .ALUSrcAPCE(nm_ALUSrcAPCE), .ImmSrcE(nm_ImmSrcE),
    .ALUControlE(nm_ALUControlE), .BranchE(nm_BranchE), .BranchTypeE(nm_BranchTypeE),
    .JumpE(nm_JumpE), .JalrE(nm_JalrE), .IllegalE(nm_IllegalE), .ill_count(nm_ill_count)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic        as;
    logic        apc;
    logic [2:0]  imm;
    logic [3:0]  alu;
    logic        br;
    logic [2:0]  bt;
    logic        j;
    logic        jr;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bundle(input string t, input vec_t v);
    chk({t, ".out_valid"},   32'(out_valid),   32'd1);
    chk({t, ".RegWriteE"},   32'(RegWriteE),   32'(v.rw));
    chk({t, ".MemWriteE"},   32'(MemWriteE),   32'(v.mw));
    chk({t, ".ResultSrcE"},  32'(ResultSrcE),  32'(v.rs));
    chk({t, ".ALUSrcE"},     32'(ALUSrcE),     32'(v.as));
    chk({t, ".ALUSrcAPCE"},  32'(ALUSrcAPCE),  32'(v.apc));
    chk({t, ".ImmSrcE"},     32'(ImmSrcE),     32'(v.imm));
    chk({t, ".ALUControlE"}, 32'(ALUControlE), 32'(v.alu));
    chk({t, ".BranchE"},     32'(BranchE),     32'(v.br));
    chk({t, ".BranchTypeE"}, 32'(BranchTypeE), 32'(v.bt));
    chk({t, ".JumpE"},       32'(JumpE),       32'(v.j));
    chk({t, ".JalrE"},       32'(JalrE),       32'(v.jr));
    chk({t, ".IllegalE"},    32'(IllegalE),    32'(v.ill));
  endtask

  // out_valid and every E control bit must be zero
  task automatic check_idle(input string t);
    chk(t, 32'({out_valid, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, ALUSrcAPCE, ImmSrcE,
                ALUControlE, BranchE, BranchTypeE, JumpE, JalrE, IllegalE}), 32'd0);
  endtask

  function automatic vec_t ill_vec(input string n, input logic [31:0] i);
    return vec_t'{n, i, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic vec_t r_vec(input string n, input logic [31:0] i, input logic [3:0] a);
    return vec_t'{n, i, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000, a, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
  endfunction

  vec_t v_add, v_sub, v_lw, v_beq, v_mul;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_ill  = 0;

    v_add = r_vec("add", 32'h003100B3, 4'd0);
    v_sub = r_vec("sub", 32'h403100B3, 4'd1);
    v_mul = r_vec("mul", 32'h023100B3, 4'd11);
    v_lw  = vec_t'{"lw", 32'h0000A283, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 3'b000, 4'd0,
                   1'b0, 3'b000, 1'b0, 1'b0, 1'b0};
    v_beq = vec_t'{"beq", 32'h00000063, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 4'd1,
                   1'b1, 3'b000, 1'b0, 1'b0, 1'b0};

    vecs.push_back(v_add);
    vecs.push_back(v_sub);
    vecs.push_back(r_vec("sll",  32'h003110B3, 4'd7));
    vecs.push_back(r_vec("slt",  32'h003120B3, 4'd5));
    vecs.push_back(r_vec("sltu", 32'h003130B3, 4'd6));
    vecs.push_back(r_vec("xor",  32'h003140B3, 4'd4));
    vecs.push_back(r_vec("srl",  32'h003150B3, 4'd8));
    vecs.push_back(r_vec("sra",  32'h403150B3, 4'd9));
    vecs.push_back(r_vec("or",   32'h003160B3, 4'd3));
    vecs.push_back(r_vec("and",  32'h003170B3, 4'd2));
    vecs.push_back(v_lw);
    vecs.push_back(vec_t'{"sw", 32'h0020A423, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 4'd0,
                          1'b0, 3'b000, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"srai", 32'h4050D093, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 4'd9,
                          1'b0, 3'b000, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"srli", 32'h0050D093, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 4'd8,
                          1'b0, 3'b000, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"addi_hi", 32'h40008093, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 4'd0,
                          1'b0, 3'b000, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"lui", 32'h12345037, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'b100, 4'd10,
                          1'b0, 3'b000, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"auipc", 32'h00000097, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 3'b100, 4'd0,
                          1'b0, 3'b000, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"jal", 32'h008000EF, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 3'b011, 4'd0,
                          1'b0, 3'b000, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"jalr", 32'h000080E7, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 3'b000, 4'd0,
                          1'b0, 3'b000, 1'b1, 1'b1, 1'b0});
    vecs.push_back(vec_t'{"blt", 32'h0020C463, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 4'd1,
                          1'b1, 3'b100, 1'b0, 1'b0, 1'b0});
    vecs.push_back(ill_vec("ill_jalr_f3", 32'h00001067));
    vecs.push_back(ill_vec("ill_r_f7",    32'h403110B3));
    vecs.push_back(ill_vec("ill_slli_f7", 32'h40009093));
    vecs.push_back(ill_vec("ill_ld",      32'h0000B003));
    vecs.push_back(ill_vec("ill_br_f3",   32'h00002063));
    vecs.push_back(ill_vec("ill_ones",    32'hFFFFFFFF));

    // reset
    reset = 1'b1; InstrD = '0; in_valid = 1'b0; flush_e = 1'b0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    check_idle("reset.idle");
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.ill_count", 32'(ill_count), 32'd0);

    // table: accept one vector, check E bundle, then let it retire
    for (int i = 0; i < vecs.size(); i++) begin
      InstrD = vecs[i].instr; in_valid = 1'b1;
      step();
      check_bundle(vecs[i].name, vecs[i]);
      if (vecs[i].ill) exp_ill++;
      in_valid = 1'b0;
      step();
      chk({vecs[i].name, ".retired"}, 32'(out_valid), 32'd0);
    end
    chk("table.ill_count", 32'(ill_count), 32'(exp_ill));

    // sub then lw back-to-back
    InstrD = v_sub.instr; in_valid = 1'b1;
    step();
    check_bundle("b2b.sub", v_sub);
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    InstrD = v_lw.instr;
    step();
    check_bundle("b2b.lw", v_lw);
    in_valid = 1'b0;
    step();

    // mul occupancy: 3 blocked cycles, accepted on the 4th
    InstrD = v_mul.instr; in_valid = 1'b1;
    step();
    check_bundle("mul", v_mul);
    chk("nm.mul.bundle", 32'({nm_out_valid, nm_RegWriteE, nm_MemWriteE, nm_ResultSrcE,
        nm_ALUSrcE, nm_ALUSrcAPCE, nm_ImmSrcE, nm_ALUControlE, nm_BranchE, nm_BranchTypeE,
        nm_JumpE, nm_JalrE, nm_IllegalE}), 32'h100001);
    chk("nm.mul.in_ready", 32'(nm_in_ready), 32'd1);
    chk("nm.mul.ill_count", 32'(nm_ill_count), 32'(exp_ill + 1));
    chk("mul.ill_count", 32'(ill_count), 32'(exp_ill));
    InstrD = v_add.instr;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("mul.busy%0d.in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("mul.busy%0d.alu", c), 32'(ALUControlE), 32'd11);
      step();
    end
    chk("mul.cycle4.in_ready", 32'(in_ready), 32'd1);
    step();
    check_bundle("mul.next_add", v_add);
    in_valid = 1'b0;
    step();

    // stall: hold E for 5 cycles, then flush
    InstrD = v_add.instr; in_valid = 1'b1;
    step();
    out_ready = 1'b0; InstrD = v_lw.instr;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
      check_bundle($sformatf("stall%0d", c), v_add);
      step();
    end
    flush_e = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    step();
    flush_e = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_idle("flush.idle");

    // beq offered with flush is refused, then accepted
    InstrD = v_beq.instr; in_valid = 1'b1; flush_e = 1'b1;
    #1;
    chk("beqflush.in_ready", 32'(in_ready), 32'd0);
    step();
    flush_e = 1'b0;
    check_idle("beqflush.idle");
    #1;
    chk("beq.in_ready", 32'(in_ready), 32'd1);
    step();
    check_bundle("beq", v_beq);
    in_valid = 1'b0;
    step();

    // illegal counter saturation
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sat.reset_count", 32'(ill_count), 32'd0);
    InstrD = 32'hFFFFFFFF; in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      step();
      if (i == 99) chk("sat.count100", 32'(ill_count), 32'd100);
    end
    chk("sat.ill_count", 32'(ill_count), 32'd255);
    chk("sat.IllegalE", 32'(IllegalE), 32'd1);
    chk("sat.MemWriteE", 32'(MemWriteE), 32'd0);
    chk("sat.RegWriteE", 32'(RegWriteE), 32'd0);
    in_valid = 1'b0; flush_e = 1'b1;
    step();
    flush_e = 1'b0;
    chk("sat.after_flush", 32'(ill_count), 32'd255);

    // reset while a mul is occupying E
    InstrD = v_mul.instr; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rstmul.busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rstmul.idle");
    chk("rstmul.in_ready", 32'(in_ready), 32'd1);
    chk("rstmul.ill_count", 32'(ill_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Next-generation RV32 control decoder with an integrated ID/EX control register.
- Decodes the full instruction word, covering RV32I plus optional M-extension, and flags illegal encodings.
- Registers the control bundle into the E stage using a valid/ready handshake, flush, and multi-cycle MUL/DIV occupancy.
- Sits between the IF/ID register and the execute stage, replacing the purely combinational decoder plus the control half of the ID/EX register.

Parameters:
- ALUCTRL_W, 4, width of ALUControl; must be ≥4.
- EN_MEXT, 1, 1 decodes MUL/MULH/DIV/REM; 0 treats them as illegal.
- MULDIV_LAT, 4, cycles an M-op occupies E, ≥1.
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- InstrD  in  32  instruction in D
- in_valid  in  1  InstrD valid
- in_ready  out  1  block accepts InstrD this cycle
- flush_e  in  1  kill E-stage contents (branch mispredict/hazard)
- out_ready  in  1  E stage may retire current op
- out_valid  out  1  E control bundle valid
- RegWriteE  out  1
- MemWriteE  out  1
- ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4
- ALUSrcE  out  1  B operand = immediate
- ALUSrcAPCE  out  1  A operand = PC (auipc)
- ImmSrcE  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControlE  out  ALUCTRL_W  operation code, see Behaviour
- BranchE  out  1
- BranchTypeE  out  3  func3 of branch
- JumpE  out  1
- JalrE  out  1
- IllegalE  out  1  registered op was illegal
- ill_count  out  ILL_CNT_W  accepted illegal instructions, saturating

Behaviour:
- Reset: all outputs and internal state are 0, except in_ready, which is combinational and equals 1 after reset.
- Decode is combinational from InstrD[6:0], [14:12], [31:25].
  - Opcode 3 (load), 35 (store), 51 (R), 19 (I-ALU), 99 (branch): control values as in the RV32 datapath.
  - Opcode 55 (lui): ImmSrc U, ALUSrc 1, ALU passB, ResultSrc 00.
  - Opcode 23 (auipc): ImmSrc U, ALUSrc 1, ALUSrcAPC 1, add.
  - Opcode 111 (jal): ImmSrc J, Jump 1, ResultSrc 10.
  - Opcode 103 (jalr, func3 = 0): ImmSrc I, ALUSrc 1, Jump 1, Jalr 1, ResultSrc 10.
- ALUControl encoding:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB
  - 11 mul, 12 mulh, 13 div, 14 rem
- Sub rule: sub only for R with func7 = 0100000 and func3 = 000.
- Shift rule: sra for func3 = 101 with func7[5] = 1 (R or I).
- Loads, stores, auipc: add. Branches: sub.
- M-ops: opcode 51 with func7 = 0000001 and func3 ∈ {000, 001, 100, 110}, only when EN_MEXT = 1.
- Illegal: any other opcode or func7/func3 combination.
  - Illegal = 1, and RegWrite, MemWrite, Branch, Jump, Jalr are all 0 (bubble-safe).
- Transfer occurs when in_valid && in_ready.
- in_ready = !flush_e && (!out_valid || (out_ready && mdu_cnt == 0)).
- On transfer: the E register loads the decoded bundle and out_valid = 1 the next cycle (1-cycle latency).
- Retire without a new transfer clears out_valid.
- While out_valid && !out_ready: hold all E outputs stable.
- MUL/DIV occupancy:
  - On transfer of an M-op, mdu_cnt loads MULDIV_LAT-1.
  - mdu_cnt decrements each cycle while nonzero; no retire is possible until it reaches 0.
  - MULDIV_LAT = 1 gives zero extra cycles.
- flush_e (highest priority after reset):
  - Next cycle: out_valid = 0, all E control bits = 0, mdu_cnt = 0.
  - InstrD offered in the same cycle is not accepted (in_ready = 0).
- ill_count increments on each transfer with Illegal = 1 and saturates at all-ones.
  - It is not cleared by flush, only by reset.
- Reset mid-operation (including mdu_cnt ≠ 0) returns everything to reset values the next edge.

Decomposition:
- Shared package (riscv_ctrl_pkg) holds:
  - opcode constants (OP_LOAD = 3, OP_STORE = 35, OP_R = 51, OP_I = 19, OP_BR = 99, OP_LUI = 55, OP_AUIPC = 23, OP_JAL = 111, OP_JALR = 103)
  - ALU_* op codes
  - IMM_*, RES_* encodings
- One sub-module, ctrl_decode_comb: pure combinational instruction-to-bundle decode.
- The top holds the handshake, E register, mdu_cnt and ill_count.

Test Plan:
- Reset, then InstrD = 0x003100B3 (add) with in_valid = 1, out_ready = 1:
  - next cycle out_valid = 1, RegWriteE = 1, ALUControlE = 0, ResultSrcE = 00, IllegalE = 0.
- 0x403100B3 (sub), then 0x0000A283 (lw) back-to-back:
  - ALUControlE = 1, then ALUControlE = 0 with ResultSrcE = 01, ALUSrcE = 1.
- 0x023100B3 (mul), MULDIV_LAT = 4, in_valid held:
  - in_ready = 0 for 3 cycles after acceptance; next op accepted on the 4th cycle; ALUControlE = 11.
  - With EN_MEXT = 0: IllegalE = 1, RegWriteE = 0.
- 0xFFFFFFFF accepted 260 times with ILL_CNT_W = 8:
  - IllegalE = 1, MemWriteE = 0, ill_count saturates at 255.
- out_valid = 1 with out_ready = 0 for 5 cycles, new instruction offered:
  - E outputs unchanged, in_ready = 0.
  - Then flush_e = 1: next cycle out_valid = 0, all controls 0.
- 0x00000063 (beq) with flush_e and in_valid asserted in the same cycle:
  - not accepted, out_valid = 0.
  - Re-offered next cycle: BranchE = 1, BranchTypeE = 000, ImmSrcE = 010, ALUControlE = 1.
